haar_cascade_engine: RTL and testbench
======================================

Name: haar_cascade_engine

Overview:
- Sequential, parametrised Haar cascade evaluator for one detection window per START pulse.
- Walks stages, features and rectangles from external stage and feature ROMs.
- Forms each rectangle sum from 4 integral-image corner reads. Accumulates left/right votes per stage and exits early on the first failing stage.
- Sits between the integral-image buffer and the window scanner. It reports is_face, the failing stage and the window origin.

Parameters:
- COORD_W, 5, width of image/window coordinates (x, y, w, h)
- II_W, 24, integral-image word width (unsigned)
- WGT_W, 3, signed rectangle weight width
- VAL_W, 16, signed width of feature threshold, left and right vote values
- ACC_W, 24, signed stage accumulator and stage-threshold width
- MAX_STAGES, 22, maximum cascade depth
- MAX_RECTS, 3, maximum rectangles per feature
- FADDR_W, 12, feature ROM address width
- SADDR_W, 5, stage ROM address width

Ports:
- Clk, in, 1, clock
- Reset, in, 1, asynchronous active-high reset
- START, in, 1, one-cycle request; sampled only while idle
- win_x, win_y, in, COORD_W each, window origin; latched on accepted START
- num_stages, in, SADDR_W, cascade depth to run; 0 is treated as 1; clamped to MAX_STAGES
- stage_addr, out, SADDR_W, stage ROM address
- stage_feat_cnt, in, FADDR_W, feature count of the addressed stage (ROM data)
- stage_thresh, in, ACC_W, signed stage threshold (ROM data)
- feat_addr, out, FADDR_W, feature ROM address; global index, stages stored back-to-back
- feat_rect_cnt, in, 2, rectangles in feature; values above MAX_RECTS clamp
- feat_rect, in, MAX_RECTS*(4*COORD_W+WGT_W), packed {x, y, w, h, weight} per rectangle, rect 0 in LSBs
- feat_thresh, in, VAL_W, signed feature threshold
- left_val, right_val, in, VAL_W each, signed votes
- ii_rd_en, out, 1, integral-image read strobe
- ii_x, ii_y, out, COORD_W each, integral-image read address
- ii_data, in, II_W, read data, valid one cycle after ii_rd_en
- busy, out, 1, high from START acceptance through the DONE cycle
- done, out, 1, one-cycle pulse when the result is valid
- is_face, out, 1, result; held until the next accepted START
- fail_stage, out, SADDR_W, index of the failing stage; num_stages when all pass
- x_out, y_out, out, COORD_W each, latched window origin

Behaviour:
- Reset (async): FSM to IDLE. busy, done, is_face, ii_rd_en = 0. fail_stage, x_out, y_out, stage_addr, feat_addr = 0. All accumulators cleared. Reset mid-evaluation discards all work; no done pulse.
- ROM data is valid one cycle after the address changes. ii_data is valid one cycle after ii_rd_en.
- States: IDLE, S_FETCH, S_LATCH, F_FETCH, F_LATCH, R_READ, F_EVAL, S_EVAL, DONE.
- IDLE: on START, latch win_x/win_y to x_out/y_out. Clear the stage index and feat_addr. Set busy and go to S_FETCH. START while busy is ignored.
- S_FETCH: drive stage_addr. S_LATCH: latch feat count and threshold, clear the stage accumulator. Count 0 goes to S_EVAL; otherwise F_FETCH.
- F_FETCH / F_LATCH: same pattern for the feature; clear the feature value. rect_cnt 0 goes to F_EVAL with value 0.
- R_READ, per rectangle: 4 reads on consecutive cycles, corners in order (X,Y), (X+w,Y), (X,Y+h), (X+w,Y+h), where X = win_x+x and Y = win_y+y.
  - Rectangle sum = D − B − C + A, computed in II_W+2 signed.
  - Add weight × sum to the feature value, held in II_W+WGT_W+2 signed.
  - Costs 5 cycles per rectangle; the next rectangle's reads start after the last corner's data returns.
  - Coordinate sums wrap modulo 2^COORD_W with no error.
- F_EVAL: value < sign-extended feat_thresh adds left_val, else adds right_val, to the stage accumulator (ACC_W, saturating). Then increment feat_addr. More features go to F_FETCH; otherwise S_EVAL.
- S_EVAL: accumulator >= stage_thresh passes. On pass, if this was the last stage: is_face = 1, fail_stage = num_stages, go to DONE; else go to S_FETCH for the next stage. On fail: is_face = 0, fail_stage = current stage, go to DONE. No further reads are issued after a fail.
- DONE: done = 1 for one cycle; busy drops on the next cycle; return to IDLE. A START in the DONE cycle is ignored.
- Latency, START edge to done high (cycles): 1 + Σ over evaluated stages of (3 + Σ over features of (3 + 5 × rects)) + 1.

Test Plan:
- 1 stage, 1 feature, 1 rect {0,0,2,2,w=+1}; II corners A=0, B=0, C=0, D=40; thresh 30, left −5, right 7, stage_thresh 5 -> done 13 cycles after START, is_face=1, fail_stage=1. ii reads at (0,0), (2,0), (0,2), (2,2) with window (0,0).
- Same setup with D=20 -> left vote −5 < 5 -> is_face=0, fail_stage=0.
- 3-stage cascade where stage 1 fails -> no ii_rd_en or stage_addr 2 activity after the S_EVAL of stage 1; fail_stage=1.
- Two rects with weights −1 and +2 (sums 10 and 8) -> feature value 6; verify against thresh 6 that right_val is selected (not-less-than case).
- START asserted while busy and in the DONE cycle -> ignored; x_out/y_out unchanged.
- Reset asserted during R_READ -> all outputs 0 immediately; no done pulse; a new START then runs cleanly to completion.

Source files
------------

// File: rtl/haar_cascade_engine.sv
// Haar cascade evaluator: walks stages/features/rects from external ROMs for one window per START.
// Latency: 1 + sum(stages: 3 + sum(features: 3 + 5*rects)) + 1 cycles from START cycle to done.
// No backpressure: START is only sampled in IDLE; ROM and integral-image reads have fixed 1-cycle latency.
module haar_cascade_engine #(
  parameter int COORD_W    = 5,
  parameter int II_W       = 24,
  parameter int WGT_W      = 3,
  parameter int VAL_W      = 16,
  parameter int ACC_W      = 24,
  parameter int MAX_STAGES = 22,
  parameter int MAX_RECTS  = 3,
  parameter int FADDR_W    = 12,
  parameter int SADDR_W    = 5
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   START,
  input  logic [COORD_W-1:0]                     win_x,
  input  logic [COORD_W-1:0]                     win_y,
  input  logic [SADDR_W-1:0]                     num_stages,
  output logic [SADDR_W-1:0]                     stage_addr,
  input  logic [FADDR_W-1:0]                     stage_feat_cnt,
  input  logic [ACC_W-1:0]                       stage_thresh,
  output logic [FADDR_W-1:0]                     feat_addr,
  input  logic [1:0]                             feat_rect_cnt,
  input  logic [MAX_RECTS*(4*COORD_W+WGT_W)-1:0] feat_rect,
  input  logic [VAL_W-1:0]                       feat_thresh,
  input  logic [VAL_W-1:0]                       left_val,
  input  logic [VAL_W-1:0]                       right_val,
  output logic                                   ii_rd_en,
  output logic [COORD_W-1:0]                     ii_x,
  output logic [COORD_W-1:0]                     ii_y,
  input  logic [II_W-1:0]                        ii_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   is_face,
  output logic [SADDR_W-1:0]                     fail_stage,
  output logic [COORD_W-1:0]                     x_out,
  output logic [COORD_W-1:0]                     y_out
);

  localparam int RECT_W = 4*COORD_W + WGT_W;
  localparam int SUM_W  = II_W + 2;
  localparam int FV_W   = II_W + WGT_W + 2;
  localparam logic [SADDR_W-1:0] MAX_ST = SADDR_W'(MAX_STAGES);
  localparam logic [1:0]         MAX_RC = 2'(MAX_RECTS);

  typedef enum logic [3:0] {
    IDLE, S_FETCH, S_LATCH, F_FETCH, F_LATCH, R_READ, F_EVAL, S_EVAL, DONE
  } state_t;

  state_t               state_q;
  logic [SADDR_W-1:0]   stage_q, nst_q, fail_q;
  logic [FADDR_W-1:0]   feat_q, feats_left_q;
  logic [ACC_W-1:0]     sthr_q, acc_q, acc_d;
  logic [1:0]           rect_cnt_q, rect_idx_q;
  logic [2:0]           corner_q;
  logic [RECT_W-1:0]    rect_q [4];
  logic [RECT_W-1:0]    rect_in [4];
  logic [VAL_W-1:0]     fthr_q, lval_q, rval_q;
  logic [FV_W-1:0]      fval_q, fval_d;
  logic [II_W-1:0]      ca_q, cb_q, cc_q;
  logic                 rd_en_q, busy_q, done_q, face_q;
  logic [COORD_W-1:0]   ii_x_q, ii_y_q, ii_x_d, ii_y_d, x_q, y_q;
  logic [SADDR_W-1:0]   n_eff;
  logic [1:0]           rc_clamp;
  logic                 feat_less, stage_pass;

  // Slots beyond MAX_RECTS read as zero so the rect index never selects undriven bits.
  for (genvar g = 0; g < 4; g++) begin : g_rect
    if (g < MAX_RECTS) begin : g_used
      assign rect_in[g] = feat_rect[g*RECT_W +: RECT_W];
    end else begin : g_unused
      assign rect_in[g] = '0;
    end
  end

  // Corner k of a rectangle: bit 0 adds w, bit 1 adds h; all sums wrap in COORD_W.
  function automatic logic [2*COORD_W-1:0] corner_xy(input logic [RECT_W-1:0] r,
                                                      input logic [1:0] k,
                                                      input logic [COORD_W-1:0] wx,
                                                      input logic [COORD_W-1:0] wy);
    logic [COORD_W-1:0] rx, ry, rw, rh, cx, cy;
    rx = r[RECT_W-1 -: COORD_W];
    ry = r[RECT_W-1-COORD_W -: COORD_W];
    rw = r[WGT_W+COORD_W +: COORD_W];
    rh = r[WGT_W +: COORD_W];
    cx = wx + rx + (k[0] ? rw : '0);
    cy = wy + ry + (k[1] ? rh : '0);
    return {cx, cy};
  endfunction

  // Effective depth and rect count after the 0->1 and max clamps.
  always_comb begin
    n_eff = num_stages;
    if (num_stages == '0) n_eff = 1;
    else if (num_stages > MAX_ST) n_eff = MAX_ST;
    rc_clamp = (feat_rect_cnt > MAX_RC) ? MAX_RC : feat_rect_cnt;
  end

  // Next read address: first corner of rect 0 straight from the ROM in F_LATCH,
  // first corner of the next rect after the last data returns, else the next corner.
  always_comb begin
    logic [RECT_W-1:0] nxt_rect;
    logic [1:0]        nxt_corner;
    nxt_rect   = rect_q[rect_idx_q];
    nxt_corner = corner_q[1:0] + 2'd1;
    if (state_q == F_LATCH) begin
      nxt_rect   = rect_in[0];
      nxt_corner = 2'd0;
    end else if (corner_q == 3'd4) begin
      nxt_rect   = rect_q[rect_idx_q + 2'd1];
      nxt_corner = 2'd0;
    end
    {ii_x_d, ii_y_d} = corner_xy(nxt_rect, nxt_corner, x_q, y_q);
  end

  // Rectangle sum D-B-C+A and weighted accumulation into the feature value.
  always_comb begin
    logic [SUM_W-1:0]  rsum;
    logic [WGT_W-1:0]  wgt;
    logic [FV_W-1:0]   wgt_x, sum_x;
    rsum   = {2'b00, ii_data} - {2'b00, cb_q} - {2'b00, cc_q} + {2'b00, ca_q};
    wgt    = rect_q[rect_idx_q][WGT_W-1:0];
    wgt_x  = {{(FV_W-WGT_W){wgt[WGT_W-1]}}, wgt};
    sum_x  = {{(FV_W-SUM_W){rsum[SUM_W-1]}}, rsum};
    fval_d = fval_q + wgt_x * sum_x;
  end

  // Feature vote selection and saturating add into the stage accumulator.
  always_comb begin
    logic [VAL_W-1:0] vote;
    logic [ACC_W:0]   acc_sum;
    feat_less  = $signed(fval_q) < $signed({{(FV_W-VAL_W){fthr_q[VAL_W-1]}}, fthr_q});
    vote       = feat_less ? lval_q : rval_q;
    acc_sum    = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-VAL_W){vote[VAL_W-1]}}, vote};
    acc_d      = acc_sum[ACC_W-1:0];
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
      acc_d = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    stage_pass = $signed(acc_q) >= $signed(sthr_q);
  end

  // Cascade walker FSM with registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      nst_q        <= '0;
      fail_q       <= '0;
      feat_q       <= '0;
      feats_left_q <= '0;
      sthr_q       <= '0;
      acc_q        <= '0;
      rect_cnt_q   <= '0;
      rect_idx_q   <= '0;
      corner_q     <= '0;
      for (int i = 0; i < 4; i++) rect_q[i] <= '0;
      fthr_q       <= '0;
      lval_q       <= '0;
      rval_q       <= '0;
      fval_q       <= '0;
      ca_q         <= '0;
      cb_q         <= '0;
      cc_q         <= '0;
      rd_en_q      <= 1'b0;
      ii_x_q       <= '0;
      ii_y_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      face_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            x_q     <= win_x;
            y_q     <= win_y;
            nst_q   <= n_eff;
            stage_q <= '0;
            feat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          feats_left_q <= stage_feat_cnt;
          sthr_q       <= stage_thresh;
          acc_q        <= '0;
          state_q      <= (stage_feat_cnt == '0) ? S_EVAL : F_FETCH;
        end
        F_FETCH: state_q <= F_LATCH;
        F_LATCH: begin
          rect_cnt_q <= rc_clamp;
          rect_q     <= rect_in;
          fthr_q     <= feat_thresh;
          lval_q     <= left_val;
          rval_q     <= right_val;
          fval_q     <= '0;
          rect_idx_q <= '0;
          corner_q   <= '0;
          if (rc_clamp == 2'd0) begin
            state_q <= F_EVAL;
          end else begin
            rd_en_q <= 1'b1;
            ii_x_q  <= ii_x_d;
            ii_y_q  <= ii_y_d;
            state_q <= R_READ;
          end
        end
        R_READ: begin
          if (corner_q == 3'd4) begin
            fval_q <= fval_d;
            if ({1'b0, rect_idx_q} + 3'd1 < {1'b0, rect_cnt_q}) begin
              rect_idx_q <= rect_idx_q + 2'd1;
              corner_q   <= '0;
              rd_en_q    <= 1'b1;
              ii_x_q     <= ii_x_d;
              ii_y_q     <= ii_y_d;
            end else begin
              state_q <= F_EVAL;
            end
          end else begin
            corner_q <= corner_q + 3'd1;
            if (corner_q == 3'd1) ca_q <= ii_data;
            if (corner_q == 3'd2) cb_q <= ii_data;
            if (corner_q == 3'd3) cc_q <= ii_data;
            if (corner_q == 3'd3) begin
              rd_en_q <= 1'b0;
            end else begin
              ii_x_q <= ii_x_d;
              ii_y_q <= ii_y_d;
            end
          end
        end
        F_EVAL: begin
          acc_q        <= acc_d;
          feat_q       <= feat_q + 1'b1;
          feats_left_q <= feats_left_q - 1'b1;
          state_q      <= (feats_left_q == 1) ? S_EVAL : F_FETCH;
        end
        S_EVAL: begin
          if (stage_pass) begin
            if (stage_q == nst_q - 1'b1) begin
              face_q  <= 1'b1;
              fail_q  <= nst_q;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              stage_q <= stage_q + 1'b1;
              state_q <= S_FETCH;
            end
          end else begin
            face_q  <= 1'b0;
            fail_q  <= stage_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stage_addr = stage_q;
  assign feat_addr  = feat_q;
  assign ii_rd_en   = rd_en_q;
  assign ii_x       = ii_x_q;
  assign ii_y       = ii_y_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign is_face    = face_q;
  assign fail_stage = fail_q;
  assign x_out      = x_q;
  assign y_out      = y_q;

endmodule

// File: tb/tb_haar_cascade_engine.sv
// Bench for haar_cascade_engine: ROM and integral-image models, directed runs,
// expected results queued at START and checked by a monitor on each done pulse.
module tb_haar_cascade_engine;
  localparam int COORD_W = 5, II_W = 24, WGT_W = 3, VAL_W = 16, ACC_W = 24;
  localparam int MAX_RECTS = 3, FADDR_W = 12, SADDR_W = 5;
  localparam int RECT_W = 4*COORD_W + WGT_W;

  logic Clk, Reset, START;
  logic [COORD_W-1:0] win_x, win_y, ii_x, ii_y, x_out, y_out;
  logic [SADDR_W-1:0] num_stages, stage_addr, fail_stage;
  logic [FADDR_W-1:0] stage_feat_cnt, feat_addr;
  logic [ACC_W-1:0]   stage_thresh;
  logic [1:0]         feat_rect_cnt;
  logic [MAX_RECTS*RECT_W-1:0] feat_rect;
  logic [VAL_W-1:0]   feat_thresh, left_val, right_val;
  logic               ii_rd_en, busy, done, is_face;
  logic [II_W-1:0]    ii_data;

  haar_cascade_engine dut (
    .Clk(Clk), .Reset(Reset), .START(START), .win_x(win_x), .win_y(win_y),
    .num_stages(num_stages), .stage_addr(stage_addr), .stage_feat_cnt(stage_feat_cnt),
    .stage_thresh(stage_thresh), .feat_addr(feat_addr), .feat_rect_cnt(feat_rect_cnt),
    .feat_rect(feat_rect), .feat_thresh(feat_thresh), .left_val(left_val),
    .right_val(right_val), .ii_rd_en(ii_rd_en), .ii_x(ii_x), .ii_y(ii_y),
    .ii_data(ii_data), .busy(busy), .done(done), .is_face(is_face),
    .fail_stage(fail_stage), .x_out(x_out), .y_out(y_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM / memory models
  logic [FADDR_W-1:0]          s_cnt [32];
  logic [ACC_W-1:0]            s_thr [32];
  logic [1:0]                  f_rc  [16];
  logic [MAX_RECTS*RECT_W-1:0] f_rect[16];
  logic [VAL_W-1:0]            f_thr [16], f_l[16], f_r[16];
  logic [II_W-1:0]             iimem [32][32];

  always @(posedge Clk) begin
    stage_feat_cnt <= s_cnt[stage_addr];
    stage_thresh   <= s_thr[stage_addr];
    feat_rect_cnt  <= f_rc[feat_addr[3:0]];
    feat_rect      <= f_rect[feat_addr[3:0]];
    feat_thresh    <= f_thr[feat_addr[3:0]];
    left_val       <= f_l[feat_addr[3:0]];
    right_val      <= f_r[feat_addr[3:0]];
    if (ii_rd_en) ii_data <= iimem[ii_x][ii_y];
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  typedef struct {
    logic               face;
    logic [SADDR_W-1:0] fs;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    int                 lat;
    int                 s;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;
  logic busy_drop_pending = 1'b0;

  logic [2*COORD_W-1:0] rd_log[$];
  int max_sa = 0;

  // Monitor: logs reads, pops the scoreboard on each done pulse
  always @(negedge Clk) begin
    if (ii_rd_en) rd_log.push_back({ii_x, ii_y});
    if (busy && int'(stage_addr) > max_sa) max_sa = int'(stage_addr);
    if (busy_drop_pending) begin
      chk("busy_drop", busy, 0);
      busy_drop_pending = 1'b0;
    end
    if (done) begin
      chk("done_expected", exp_q.size() == 0, 0);
      if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        chk("is_face", is_face, e_mon.face);
        chk("fail_stage", fail_stage, e_mon.fs);
        chk("x_out", x_out, e_mon.x);
        chk("y_out", y_out, e_mon.y);
        chk("latency", cyc - e_mon.s + 1, e_mon.lat);
        chk("busy_at_done", busy, 1);
        busy_drop_pending = 1'b1;
      end
    end
  end

  function automatic logic [RECT_W-1:0] mk_rect(input int x, y, w, h, wt);
    return {COORD_W'(x), COORD_W'(y), COORD_W'(w), COORD_W'(h), WGT_W'(wt)};
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 32; i++) begin
      s_cnt[i] = '0; s_thr[i] = '0;
      for (int j = 0; j < 32; j++) iimem[i][j] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      f_rc[i] = '0; f_rect[i] = '0; f_thr[i] = '0; f_l[i] = '0; f_r[i] = '0;
    end
  endtask

  task automatic set_feat(input int idx, rc, input logic [RECT_W-1:0] r0, r1,
                          input int thr, l, r);
    f_rc[idx]   = 2'(rc);
    f_rect[idx] = {{RECT_W{1'b0}}, r1, r0};
    f_thr[idx]  = VAL_W'(thr);
    f_l[idx]    = VAL_W'(l);
    f_r[idx]    = VAL_W'(r);
  endtask

  task automatic start_run(input int x, y, ns, input logic face, input int fs, lat);
    exp_t e;
    @(negedge Clk);
    START = 1'b1; win_x = COORD_W'(x); win_y = COORD_W'(y); num_stages = SADDR_W'(ns);
    e.face = face; e.fs = SADDR_W'(fs); e.x = COORD_W'(x); e.y = COORD_W'(y);
    e.lat = lat; e.s = cyc;
    exp_q.push_back(e);
    @(negedge Clk);
    START = 1'b0;
  endtask

  task automatic wait_sb(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge Clk);
      k++;
    end
    chk({tag, "_timeout"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge Clk);
  endtask

  task automatic check_reads(input string tag, input int x0, y0, w, h);
    int ex[4], ey[4];
    ex = '{x0, x0 + w, x0, x0 + w};
    ey = '{y0, y0, y0 + h, y0 + h};
    chk({tag, "_rd_cnt"}, rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      chk($sformatf("%s_rd%0d_x", tag, i), rd_log[i][2*COORD_W-1:COORD_W], ex[i]);
      chk($sformatf("%s_rd%0d_y", tag, i), rd_log[i][COORD_W-1:0], ey[i]);
    end
  endtask

  // Single-rect single-feature stage config: D at (dx,dy), votes -5/+7, feature thr 30, stage thr 5
  task automatic cfg_basic(input int dx, dy, dval);
    clear_all();
    s_cnt[0] = 1; s_thr[0] = 5;
    set_feat(0, 1, mk_rect(0, 0, 2, 2, 1), '0, 30, -5, 7);
    iimem[dx][dy] = II_W'(dval);
  endtask

  initial begin
    int k;
    Reset = 1'b1; START = 1'b0; win_x = '0; win_y = '0; num_stages = 5'd1;
    clear_all();
    repeat (3) @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_is_face", is_face, 0);
    chk("rst_ii_rd_en", ii_rd_en, 0);
    chk("rst_fail_stage", fail_stage, 0);
    chk("rst_feat_addr", feat_addr, 0);
    Reset = 1'b0;

    // T1: D=40 -> right vote 7 >= 5, face
    cfg_basic(2, 2, 40);
    rd_log.delete();
    start_run(0, 0, 1, 1'b1, 1, 13);
    wait_sb("t1");
    check_reads("t1", 0, 0, 2, 2);

    // T2: D=20 -> left vote -5 < 5, fails stage 0; window offset (3,4)
    cfg_basic(5, 6, 20);
    rd_log.delete();
    start_run(3, 4, 1, 1'b0, 0, 13);
    wait_sb("t2");
    check_reads("t2", 3, 4, 2, 2);

    // T3: 3 stages, stage 1 fails; stage 2 never touched
    clear_all();
    iimem[2][2] = 40;
    s_cnt[0] = 1; s_thr[0] = 5;
    s_cnt[1] = 1; s_thr[1] = 0;
    s_cnt[2] = 1; s_thr[2] = 0;
    set_feat(0, 1, mk_rect(0, 0, 2, 2, 1), '0, 30, -5, 7);
    set_feat(1, 1, mk_rect(0, 0, 2, 2, 1), '0, 50, -3, 4);
    set_feat(2, 1, mk_rect(0, 0, 2, 2, 1), '0, 0, 9, 9);
    rd_log.delete();
    max_sa = 0;
    start_run(0, 0, 3, 1'b0, 1, 24);
    wait_sb("t3");
    chk("t3_rd_cnt", rd_log.size(), 8);
    chk("t3_max_stage_addr", max_sa, 1);
    chk("t3_feat_addr", feat_addr, 2);

    // T4: weights -1 and +2, sums 10 and 8 -> value 6 == thr 6 -> right vote; num_stages 0 acts as 1
    clear_all();
    s_cnt[0] = 1; s_thr[0] = 9;
    set_feat(0, 2, mk_rect(0, 0, 1, 1, -1), mk_rect(4, 4, 1, 1, 2), 6, -9, 9);
    iimem[1][1] = 10;
    iimem[4][4] = 2; iimem[5][4] = 3; iimem[4][5] = 4; iimem[5][5] = 13;
    rd_log.delete();
    start_run(0, 0, 0, 1'b1, 1, 18);
    wait_sb("t4");
    chk("t4_rd_cnt", rd_log.size(), 8);

    // T5: START while busy and in the DONE cycle is ignored
    cfg_basic(9, 11, 40);
    start_run(7, 9, 1, 1'b1, 1, 13);
    repeat (3) @(negedge Clk);
    START = 1'b1; win_x = 5'd1; win_y = 5'd1;
    @(negedge Clk);
    START = 1'b0;
    k = 0;
    while (!done && k < 50) begin
      @(negedge Clk);
      k++;
    end
    chk("t5_done_seen", done, 1);
    START = 1'b1; win_x = 5'd2; win_y = 5'd2;
    @(negedge Clk);
    START = 1'b0;
    repeat (3) @(negedge Clk);
    chk("t5_idle_busy", busy, 0);
    chk("t5_x_hold", x_out, 7);
    chk("t5_y_hold", y_out, 9);
    wait_sb("t5");

    // T6: reset during R_READ discards the run, then a clean rerun
    start_run(7, 9, 1, 1'b1, 1, 13);
    k = 0;
    while (!ii_rd_en && k < 50) begin
      @(negedge Clk);
      k++;
    end
    chk("t6_in_rread", ii_rd_en, 1);
    Reset = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_busy", busy, 0);
    chk("t6_ii_rd_en", ii_rd_en, 0);
    chk("t6_is_face", is_face, 0);
    chk("t6_fail_stage", fail_stage, 0);
    chk("t6_x_out", x_out, 0);
    chk("t6_y_out", y_out, 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (20) @(negedge Clk);
    chk("t6_idle", busy, 0);
    start_run(7, 9, 1, 1'b1, 1, 13);
    wait_sb("t6_rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
